// File: rtl/uart_alu_core.sv
`default_nettype none
// ============================================================================
// Module  : uart_alu_core
// Purpose : Packet-level command processor between the uart_rx and uart_tx
//           AXI-stream ports. It parses an opcode/reserved/length header,
//           then runs ECHO (passthrough), ADD or MUL (shift-add) over the
//           operand payload and streams the result bytes back, LSB first.
//           Malformed packets are drained and answered with a single 0xEE.
// Ports   : clk_i          - single clock
//           rst_ni         - asynchronous active-low reset
//           s_axis_t*      - byte stream in (from uart_rx)
//           m_axis_t*      - byte stream out (to uart_tx)
//           busy_o         - high whenever the core is not waiting for a header
//           err_o          - one-cycle pulse when a header is rejected
// Revision: 1.0 - initial release
// ============================================================================
module uart_alu_core #(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_WIDTH = 32,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int HB  = 2 + LEN_WIDTH / DATA_WIDTH;   // header bytes
  localparam int OB  = OPERAND_WIDTH / DATA_WIDTH;   // bytes per operand
  localparam int HCW = $clog2(HB + 1);
  localparam int OCW = $clog2(OB + 1);
  localparam int MCW = $clog2(OPERAND_WIDTH + 1);

  localparam logic [HCW-1:0]        HDR_LAST  = HCW'(HB - 1);
  localparam logic [HCW-1:0]        HDR_LEN0  = HCW'(2);
  localparam logic [OCW-1:0]        OPND_LAST = OCW'(OB - 1);
  localparam logic [MCW-1:0]        MUL_LAST  = MCW'(OPERAND_WIDTH - 1);
  localparam logic [LEN_WIDTH-1:0]  HB_L      = LEN_WIDTH'(HB);
  localparam logic [LEN_WIDTH-1:0]  OB_L      = LEN_WIDTH'(OB);
  localparam logic [LEN_WIDTH-1:0]  ONE_L     = LEN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] OP_ECHO   = DATA_WIDTH'(8'hEC);
  localparam logic [DATA_WIDTH-1:0] OP_ADD    = DATA_WIDTH'(8'h10);
  localparam logic [DATA_WIDTH-1:0] OP_MUL    = DATA_WIDTH'(8'h11);
  localparam logic [DATA_WIDTH-1:0] ERR_BYTE  = DATA_WIDTH'(8'hEE);

  typedef enum logic [2:0] {
    S_HDR, S_ECHO, S_OPND, S_MUL, S_RESULT, S_DRAIN, S_ERR
  } state_e;

  state_e                   state_q,    state_d;
  logic                     live_q,     live_d;     // low only until the first edge after reset
  logic [HCW-1:0]           hdr_idx_q,  hdr_idx_d;
  logic [DATA_WIDTH-1:0]    op_q,       op_d;
  logic [LEN_WIDTH-1:0]     len_q,      len_d;
  logic [LEN_WIDTH-1:0]     rem_q,      rem_d;      // payload bytes still to come
  logic [OCW-1:0]           byte_idx_q, byte_idx_d;
  logic [OPERAND_WIDTH-1:0] opnd_q,     opnd_d;
  logic [OPERAND_WIDTH-1:0] acc_q,      acc_d;
  logic [OPERAND_WIDTH-1:0] prod_q,     prod_d;
  logic                     first_q,    first_d;
  logic [MCW-1:0]           mul_cnt_q,  mul_cnt_d;

  // Little-endian byte assembly: each new byte enters at the top and the
  // register shifts right, so the first byte ends up in the LSBs.
  logic [LEN_WIDTH-1:0]     len_full;
  logic [LEN_WIDTH-1:0]     payload;
  logic [OPERAND_WIDTH-1:0] opnd_full;
  logic [OPERAND_WIDTH-1:0] prod_next;

  assign len_full  = (len_q >> DATA_WIDTH) |
                     (LEN_WIDTH'(s_axis_tdata) << (LEN_WIDTH - DATA_WIDTH));
  assign payload   = len_full - HB_L;
  assign opnd_full = (opnd_q >> DATA_WIDTH) |
                     (OPERAND_WIDTH'(s_axis_tdata) << (OPERAND_WIDTH - DATA_WIDTH));
  // In MUL, acc_q holds the shifting multiplicand and opnd_q the multiplier.
  assign prod_next = prod_q + (opnd_q[0] ? acc_q : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_HDR;
      live_q     <= 1'b0;
      hdr_idx_q  <= '0;
      op_q       <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      byte_idx_q <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      first_q    <= 1'b0;
      mul_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      hdr_idx_q  <= hdr_idx_d;
      op_q       <= op_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      byte_idx_q <= byte_idx_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      first_q    <= first_d;
      mul_cnt_q  <= mul_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    live_d        = 1'b1;
    hdr_idx_d     = hdr_idx_q;
    op_d          = op_q;
    len_d         = len_q;
    rem_d         = rem_q;
    byte_idx_d    = byte_idx_q;
    opnd_d        = opnd_q;
    acc_d         = acc_q;
    prod_d        = prod_q;
    first_d       = first_q;
    mul_cnt_d     = mul_cnt_q;
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    err_o         = 1'b0;
    busy_o        = (state_q != S_HDR);

    unique case (state_q)
      S_HDR: begin
        s_axis_tready = live_q;
        if (s_axis_tvalid && live_q) begin
          if (hdr_idx_q == '0)       op_d  = s_axis_tdata;
          if (hdr_idx_q >= HDR_LEN0) len_d = len_full;
          if (hdr_idx_q == HDR_LAST) begin
            hdr_idx_d  = '0;
            rem_d      = payload;
            byte_idx_d = '0;
            first_d    = 1'b1;
            if (op_q == OP_ECHO && len_full > HB_L) begin
              state_d = S_ECHO;
            end else if (op_q == OP_ECHO && len_full == HB_L) begin
              state_d = S_HDR;
            end else if ((op_q == OP_ADD || op_q == OP_MUL) && len_full > HB_L &&
                         (payload % OB_L) == '0) begin
              state_d = S_OPND;
            end else begin
              err_o   = 1'b1;
              state_d = (len_full > HB_L) ? S_DRAIN : S_ERR;
            end
          end else begin
            hdr_idx_d = hdr_idx_q + HCW'(1);
          end
        end
      end

      S_ECHO: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          rem_d = rem_q - ONE_L;
          if (rem_q == ONE_L) state_d = S_HDR;
        end
      end

      S_OPND: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          opnd_d = opnd_full;
          rem_d  = rem_q - ONE_L;
          if (byte_idx_q == OPND_LAST) begin
            byte_idx_d = '0;
            first_d    = 1'b0;
            if (first_q || op_q == OP_ADD) begin
              acc_d   = first_q ? opnd_full : acc_q + opnd_full;
              state_d = (rem_q == ONE_L) ? S_RESULT : S_OPND;
            end else begin
              prod_d    = '0;
              mul_cnt_d = '0;
              state_d   = S_MUL;
            end
          end else begin
            byte_idx_d = byte_idx_q + OCW'(1);
          end
        end
      end

      S_MUL: begin
        prod_d    = prod_next;
        acc_d     = acc_q << 1;
        opnd_d    = opnd_q >> 1;
        mul_cnt_d = mul_cnt_q + MCW'(1);
        if (mul_cnt_q == MUL_LAST) begin
          acc_d     = prod_next;
          mul_cnt_d = '0;
          // rem_q already reached zero if the operand just multiplied was the last.
          state_d   = (rem_q == '0) ? S_RESULT : S_OPND;
        end
      end

      S_RESULT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = acc_q[DATA_WIDTH-1:0];
        if (m_axis_tready) begin
          acc_d      = acc_q >> DATA_WIDTH;
          byte_idx_d = byte_idx_q + OCW'(1);
          if (byte_idx_q == OPND_LAST) begin
            byte_idx_d = '0;
            state_d    = S_HDR;
          end
        end
      end

      S_DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          rem_d = rem_q - ONE_L;
          if (rem_q == ONE_L) state_d = S_ERR;
        end
      end

      S_ERR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = ERR_BYTE;
        if (m_axis_tready) state_d = S_HDR;
      end

      default: state_d = S_HDR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_alu_core
// Purpose : Self-checking bench for uart_alu_core. A packet-level reference
//           model predicts the reply bytes and error pulses of each packet;
//           a separate monitor pops and compares every byte the core emits.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_alu_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       busy;
  logic       err;

  uart_alu_core #(.DATA_WIDTH(8), .OPERAND_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         exp_err = 0;
  int         err_seen = 0;
  int         rdy_mode = 0;     // 0: always ready, 1: random, 2: pattern 1,0,0,1
  int         pat_idx = 0;
  bit         gap_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- tx-side ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: m_tready = 1'($urandom_range(0, 1));
        2: begin
          m_tready = (pat_idx == 0 || pat_idx == 3);
          pat_idx  = (pat_idx + 1) % 4;
        end
        default: m_tready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("tx_hold_stable", {m_tvalid, m_tdata}, {1'b1, prev_data});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("tx_unexpected_byte", {24'h0, m_tdata}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'h0, m_tdata}, {24'h0, exp_q.pop_front()});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      if (err) err_seen++;
    end
  end

  // ---------------- reference model: whole-packet semantics ----------------
  task automatic model_pkt();
    int          op;
    int          len;
    int          n;
    logic [31:0] acc;
    logic [31:0] v;
    logic [63:0] p;
    op  = pkt_q[0];
    len = {pkt_q[3], pkt_q[2]};
    if (op == 8'hEC && len >= 4) begin
      for (int i = 4; i < len; i++) exp_q.push_back(pkt_q[i]);
    end else if ((op == 8'h10 || op == 8'h11) && len > 4 && (len - 4) % 4 == 0) begin
      n   = (len - 4) / 4;
      acc = 0;
      for (int k = 0; k < n; k++) begin
        v = {pkt_q[4+4*k+3], pkt_q[4+4*k+2], pkt_q[4+4*k+1], pkt_q[4+4*k]};
        if (k == 0)          acc = v;
        else if (op == 8'h10) acc = acc + v;
        else begin
          p   = 64'(acc) * 64'(v);
          acc = p[31:0];
        end
      end
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8 * b)));
    end else begin
      exp_err++;
      exp_q.push_back(8'hEE);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic hdr(input logic [7:0] op, input int len);
    pkt_q.delete();
    pkt_q.push_back(op);
    pkt_q.push_back(8'($urandom));
    pkt_q.push_back(8'(len));
    pkt_q.push_back(8'(len >> 8));
  endtask

  task automatic word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) pkt_q.push_back(8'(w >> (8 * b)));
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t        = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) check("rx_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt();
    model_pkt();
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", t < 2000, 1);
    check("err_pulses", err_seen, exp_err);
  endtask

  task automatic wait_first_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_tvalid && lat < 200);
  endtask

  // ---------------- main sequence ----------------
  int lat;
  int kind;
  int n;
  logic [7:0] op;

  initial begin
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata",  m_tdata,  0);
    check("rst_busy",     busy,     0);
    check("rst_err",      err,      0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_s_tready", s_tready, 1);

    // ADD 1 + 2 with exact one-cycle latency
    hdr(8'h10, 12); word(32'd1); word(32'd2);
    send_pkt();
    wait_first_valid(lat);
    check("add_latency", lat, 1);
    wait_idle();

    // MUL 3 * 0xFFFFFFFF wraps; first byte valid 33 cycles after last rx byte
    hdr(8'h11, 12); word(32'd3); word(32'hFFFF_FFFF);
    send_pkt();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 10) check("mul_busy", busy, 1);
    end while (!m_tvalid && lat < 200);
    check("mul_latency", lat, 33);
    wait_idle();

    // ECHO under a 1,0,0,1 ready pattern
    rdy_mode = 2;
    hdr(8'hEC, 7); pkt_q.push_back(8'h41); pkt_q.push_back(8'h42); pkt_q.push_back(8'h43);
    send_pkt();
    wait_idle();
    rdy_mode = 0;

    // Bad length: payload of 2 is drained, then a normal ADD
    hdr(8'h10, 6); pkt_q.push_back(8'hAA); pkt_q.push_back(8'hBB);
    send_pkt();
    wait_idle();
    hdr(8'h10, 12); word(32'h1234_5678); word(32'h1111_1111);
    send_pkt();
    wait_idle();

    // Unknown opcode with drain; short packet without drain
    hdr(8'h55, 5); pkt_q.push_back(8'h99);
    send_pkt();
    wait_idle();
    hdr(8'h10, 3);
    send_pkt();
    wait_idle();

    // Reset in the middle of an ADD packet
    hdr(8'h10, 12); word(32'd9); word(32'd9);
    for (int i = 0; i < 6; i++) send_byte(pkt_q[i]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_m_tdata",  m_tdata,  0);
    check("mid_rst_busy",     busy,     0);
    check("mid_rst_err",      err,      0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hdr(8'h10, 12); word(32'd5); word(32'd7);
    send_pkt();
    wait_idle();

    // Randomized packets with rx gaps and tx backpressure
    gap_en   = 1'b1;
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          n = $urandom_range(0, 5);
          hdr(8'hEC, 4 + n);
          for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
        end
        1, 2: begin
          n = $urandom_range(1, 3);
          hdr(kind == 1 ? 8'h10 : 8'h11, 4 + 4 * n);
          for (int i = 0; i < n; i++)
            word($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)));
        end
        3: begin
          n = 4 * $urandom_range(0, 1) + $urandom_range(1, 3);
          hdr($urandom_range(0, 1) ? 8'h10 : 8'h11, 4 + n);
          for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
        end
        4: begin
          do op = 8'($urandom); while (op == 8'hEC || op == 8'h10 || op == 8'h11);
          n = $urandom_range(0, 3);
          hdr(op, 4 + n);
          for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
        end
        default: begin
          case ($urandom_range(0, 2))
            0:       op = 8'hEC;
            1:       op = 8'h10;
            default: op = 8'h11;
          endcase
          hdr(op, $urandom_range(0, 3));
        end
      endcase
      send_pkt();
      wait_idle();
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_alu_core.md
Name: uart_alu_core

Overview:
Packet-level command processor between the uart_rx AXI-stream output and the uart_tx AXI-stream input. It parses byte packets of the form header + operand payload, executes ECHO, ADD or MUL over N operands of parametrised width, and streams the result bytes back. It replaces the bare uart_tx/uart_rx wrapper as the compute core of the UART ALU top.

Parameters:
DATA_WIDTH, 8, AXI-stream byte width; must equal the uart_tx/uart_rx DATA_WIDTH.
OPERAND_WIDTH, 32, operand and result width; must be a multiple of DATA_WIDTH.
LEN_WIDTH, 16, width of the packet length field; the field is LEN_WIDTH/DATA_WIDTH bytes, little-endian.

Ports:
clk_i  input  1  single clock
rst_ni  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_WIDTH  byte from uart_rx
s_axis_tvalid  input  1  rx byte valid
s_axis_tready  output  1  core accepts rx byte
m_axis_tdata  output  DATA_WIDTH  byte to uart_tx
m_axis_tvalid  output  1  tx byte valid
m_axis_tready  input  1  uart_tx accepts byte
busy_o  output  1  high in every state except HDR
err_o  output  1  one-cycle pulse when a packet is rejected

Behaviour:
- A transfer occurs when tvalid and tready are both high on a rising clk_i edge. The m_axis data/valid pair holds stable until accepted.
- Packet format: opcode byte, reserved byte (ignored), length field (LSB first). Length counts total packet bytes including the header. HB = 2 + LEN_WIDTH/8, and HB = 4 by default. OB = OPERAND_WIDTH/8 bytes per operand, LSB first.
- Opcodes: 0xEC ECHO, 0x10 ADD, 0x11 MUL.
- States: HDR, ECHO, OPND, MUL, RESULT, DRAIN, ERR.
- HDR: s_axis_tready=1. After the last header byte:
  - ECHO with len>HB → ECHO.
  - ECHO with len==HB → HDR.
  - ADD/MUL with len>HB and (len-HB)%OB==0 → OPND.
  - Otherwise → DRAIN if len>HB, else ERR. err_o pulses in this cycle.
- ECHO: combinational passthrough, m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready. A remaining-byte counter decrements per transfer. Go to HDR after the last byte.
- OPND: s_axis_tready=1. Bytes shift into an operand register. On each completed operand:
  - First operand: acc := operand.
  - ADD: acc := acc + operand, mod 2^OPERAND_WIDTH.
  - MUL: enter MUL with s_axis_tready=0.
  - After the last operand → RESULT.
- MUL: shift-add, exactly OPERAND_WIDTH cycles. acc := (acc*operand) mod 2^OPERAND_WIDTH. Then return to OPND, or go to RESULT if this was the last operand.
- RESULT: emit OB bytes of acc, LSB first, with m_axis_tvalid=1 and s_axis_tready=0. Go to HDR after the last byte is accepted.
- DRAIN: s_axis_tready=1. Discard len-HB bytes, then → ERR.
- ERR: emit the single byte 0xEE, then → HDR.
- Latency:
  - ADD: first result byte valid the cycle after the last operand byte is accepted.
  - MUL: valid OPERAND_WIDTH+1 cycles after it.
- Backpressure: m_axis_tready low stalls RESULT/ERR/ECHO indefinitely with no byte lost or duplicated. s_axis_tvalid gaps stall parsing.
- Reset (asynchronous, any state, mid-packet included):
  - State → HDR; counters, acc and operand register → 0.
  - s_axis_tready=0 while rst_ni is low, then 1 in HDR.
  - m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, err_o=0.
  - A partially received packet is abandoned.
- A length field of 0xFFFF is legal. Counters are LEN_WIDTH wide and never wrap within a packet.

Test Plan:
- ADD: rx 10 00 0C 00 01 00 00 00 02 00 00 00 → tx 03 00 00 00; err_o stays 0.
- MUL with wrap: rx 11 00 0C 00 03 00 00 00 FF FF FF FF → tx FD FF FF FF. First tx valid exactly 33 cycles after the last rx byte is accepted.
- ECHO with backpressure: rx EC 00 07 00 41 42 43 while m_axis_tready toggles 1,0,0,1 → tx 41 42 43 in order, no duplicates.
- Bad length: rx 10 00 06 00 AA BB → err_o pulse, 2 bytes drained, tx EE. A following valid ADD packet is processed normally.
- Unknown opcode and short packet:
  - rx 55 00 05 00 99 → tx EE.
  - rx 10 00 03 00 → tx EE with no drain.
- Reset mid-packet: assert rst_ni low after 6 bytes of an ADD packet → all outputs at reset values immediately. After release, a fresh ADD packet with operands 5 and 7 → tx 0C 00 00 00.
